alu_cmd_sequencer: RTL and testbench

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command sequencer: collects opcode/operand frames, drives an
// external adder through registered operands, and returns result/flags bytes
// through a handshaked transmitter.
module alu_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 120000,
    parameter logic [7:0]  ERR_BYTE       = 8'hEE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_result,
    input  logic [7:0] alu_flags,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    output logic       busy,
    output logic       timeout_err,
    output logic       rx_overrun
);

    localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  OP_ADD_FULL = 8'h01;
    localparam logic [7:0]  OP_ADD_RES  = 8'h02;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GET_A = 3'd1,
        GET_B = 3'd2,
        EXEC  = 3'd3,
        SEND  = 3'd4,
        HOLD  = 3'd5,
        WAIT  = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         alu_a_q, alu_a_d;
    logic [7:0]         alu_b_q, alu_b_d;
    logic               full_q, full_d;        // frame returns the flags byte too
    logic               more_q, more_d;        // flags byte still to be sent
    logic [7:0]         byte_q, byte_d;        // byte queued for the next SEND
    logic [7:0]         flags_q, flags_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               busy_q, busy_d;
    logic               tmo_q, tmo_d;
    logic               ovr_q, ovr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            alu_a_q    <= 8'h00;
            alu_b_q    <= 8'h00;
            full_q     <= 1'b0;
            more_q     <= 1'b0;
            byte_q     <= 8'h00;
            flags_q    <= 8'h00;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            tmo_q      <= 1'b0;
            ovr_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            full_q     <= full_d;
            more_q     <= more_d;
            byte_q     <= byte_d;
            flags_q    <= flags_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            ovr_q      <= ovr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state and next-output logic for the frame sequencer
    always_comb begin
        state_d    = state_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        full_d     = full_q;
        more_d     = more_q;
        byte_d     = byte_q;
        flags_d    = flags_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        tmo_d      = tmo_q;
        ovr_d      = ovr_q;
        cnt_d      = '0;

        case (state_q)
            IDLE: begin
                if (rx_ready) begin
                    if (rx_data == OP_ADD_FULL || rx_data == OP_ADD_RES) begin
                        full_d  = (rx_data == OP_ADD_FULL);
                        state_d = GET_A;
                    end else begin
                        byte_d  = ERR_BYTE;
                        more_d  = 1'b0;
                        state_d = SEND;
                    end
                end
            end
            GET_A: begin
                if (rx_ready) begin
                    alu_a_d = rx_data;
                    state_d = GET_B;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            GET_B: begin
                if (rx_ready) begin
                    alu_b_d = rx_data;
                    state_d = EXEC;
                end else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            EXEC: begin
                flags_d = alu_flags;
                byte_d  = alu_result;
                more_d  = full_q;
                state_d = SEND;
            end
            SEND: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = byte_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                // Transmitter may not have raised busy yet
                state_d = WAIT;
            end
            WAIT: begin
                if (!tx_busy) begin
                    if (more_q) begin
                        byte_d  = flags_q;
                        more_d  = 1'b0;
                        state_d = SEND;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bytes arriving while results are being produced are discarded
        if (rx_ready && (state_q == EXEC || state_q == SEND ||
                         state_q == HOLD || state_q == WAIT)) begin
            ovr_d = 1'b1;
        end
    end

    assign busy_d      = (state_d != IDLE);

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;
    assign rx_overrun  = ovr_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Randomised scoreboard bench for alu_cmd_sequencer with a behavioural
// adder, a transmitter model and directed scenarios for the corner cases.
module tb_alu_cmd_sequencer;

    localparam int unsigned T   = 40;
    localparam logic [7:0]  ERR = 8'hEE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic [7:0] alu_a, alu_b, alu_result, alu_flags;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       busy, timeout_err, rx_overrun;

    always #5 clk = ~clk;

    // Z80-style ADD flags {S,Z,0,H,0,PV,N,C} from plain integer arithmetic
    function automatic logic [7:0] flags_f(input logic [7:0] a, input logic [7:0] b);
        int s  = int'(a) + int'(b);
        int sa = (a > 127) ? int'(a) - 256 : int'(a);
        int sb = (b > 127) ? int'(b) - 256 : int'(b);
        int ss = sa + sb;
        logic [7:0] f = 8'h00;
        f[7] = ((s % 256) >= 128);
        f[6] = ((s % 256) == 0);
        f[4] = ((int'(a) % 16 + int'(b) % 16) > 15);
        f[2] = (ss > 127 || ss < -128);
        f[0] = (s > 255);
        return f;
    endfunction

    function automatic logic [7:0] sum_f(input logic [7:0] a, input logic [7:0] b);
        int s = (int'(a) + int'(b)) % 256;
        return 8'(s);
    endfunction

    assign alu_result = sum_f(alu_a, alu_b);
    assign alu_flags  = flags_f(alu_a, alu_b);

    alu_cmd_sequencer #(.TIMEOUT_CYCLES(T), .ERR_BYTE(ERR)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_flags(alu_flags),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy),
        .timeout_err(timeout_err), .rx_overrun(rx_overrun)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         tx_cnt = 0;
    logic       prev_busy = 1'b0;
    logic       prev_start = 1'b0;
    logic       busy_force = 1'b0;
    int         model_cnt = 0;
    logic [7:0] model_a = 8'h00, model_b = 8'h00;
    logic       model_tmo = 1'b0, model_ovr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitor: every transmit request is checked against the scoreboard
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            tx_cnt++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_unexpected: got byte %0h, required no transmission", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
            check("tx_start_while_busy", prev_busy, 1'b0);
            check("tx_start_back_to_back", prev_start, 1'b0);
        end
        prev_busy  = tx_busy;
        prev_start = tx_start;
    end

    // Transmitter model: busy for a few cycles after each request
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (model_cnt > 0) model_cnt--;
            if (tx_start) model_cnt = $urandom_range(3, 8);
            tx_busy = busy_force || (model_cnt > 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input int gap);
        cyc(gap);
        rx_data  = d;
        rx_ready = 1'b1;
        cyc(1);
        rx_ready = 1'b0;
    endtask

    // Issue one frame and push the response the rules predict
    task automatic do_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                            input int ga, input int gb, input logic inject);
        send_byte(op, $urandom_range(0, 3));
        if (op != 8'h01 && op != 8'h02) begin
            exp_q.push_back(ERR);
            return;
        end
        if (ga >= int'(T)) begin
            cyc(ga + 2);
            model_tmo = 1'b1;
            return;
        end
        send_byte(a, ga);
        model_a = a;
        if (gb >= int'(T)) begin
            cyc(gb + 2);
            model_tmo = 1'b1;
            return;
        end
        send_byte(b, gb);
        model_b = b;
        exp_q.push_back(sum_f(a, b));
        if (op == 8'h01) exp_q.push_back(flags_f(a, b));
        if (inject) begin
            send_byte(8'hAA, $urandom_range(0, 2));
            model_ovr = 1'b1;
        end
    endtask

    task automatic wait_done();
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < 3000) begin
            cyc(1);
            k++;
        end
        if (k >= 3000) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_done: got busy=%0b pending=%0d, required idle and drained",
                     busy, exp_q.size());
        end
        cyc(2);
        check("busy_end", busy, 1'b0);
        check("alu_a", alu_a, model_a);
        check("alu_b", alu_b, model_b);
        check("timeout_err", timeout_err, model_tmo);
        check("rx_overrun", rx_overrun, model_ovr);
    endtask

    task automatic check_reset_values();
        check("rst_alu_a", alu_a, 8'h00);
        check("rst_alu_b", alu_b, 8'h00);
        check("rst_tx_start", tx_start, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout_err", timeout_err, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);
    endtask

    initial begin
        int c0;
        int k;
        logic [7:0] op;
        int ga, gb;

        rst_n = 1'b0;
        cyc(3);
        check_reset_values();
        rst_n = 1'b1;
        cyc(2);

        // Known-answer frames
        do_frame(8'h01, 8'h10, 8'h20, 0, 0, 1'b0); wait_done();
        do_frame(8'h01, 8'hFF, 8'h01, 1, 2, 1'b0); wait_done();
        do_frame(8'h01, 8'h7F, 8'h01, 0, 3, 1'b0); wait_done();
        do_frame(8'h55, 8'h00, 8'h00, 0, 0, 1'b0); wait_done();
        do_frame(8'h02, 8'h03, 8'h04, 0, 0, 1'b0); wait_done();

        // Byte arriving on the expiry cycle wins, then a real timeout
        do_frame(8'h02, 8'h05, 8'h06, int'(T) - 1, int'(T) - 1, 1'b0); wait_done();
        c0 = tx_cnt;
        do_frame(8'h01, 8'h10, 8'h00, 0, int'(T), 1'b0); wait_done();
        check("timeout_no_tx", tx_cnt, c0);
        do_frame(8'h02, 8'h01, 8'h01, 0, 0, 1'b0); wait_done();

        // Overrun while transmitter held busy for 50 cycles
        busy_force = 1'b1;
        c0 = tx_cnt;
        do_frame(8'h01, 8'h10, 8'h20, 0, 0, 1'b1);
        cyc(50);
        check("held_off_no_tx", tx_cnt, c0);
        busy_force = 1'b0;
        wait_done();
        check("held_off_two_bytes", tx_cnt, c0 + 2);

        // Reset while waiting between result and flags bytes
        c0 = tx_cnt;
        do_frame(8'h01, 8'h10, 8'h20, 0, 0, 1'b0);
        k = 0;
        while (tx_cnt == c0 && k < 500) begin
            cyc(1);
            k++;
        end
        check("first_byte_seen", tx_cnt, c0 + 1);
        busy_force = 1'b1;
        cyc(3);
        rst_n = 1'b0;
        cyc(2);
        check_reset_values();
        exp_q.delete();
        model_a = 8'h00; model_b = 8'h00; model_tmo = 1'b0; model_ovr = 1'b0;
        rst_n = 1'b1;
        busy_force = 1'b0;
        c0 = tx_cnt;
        cyc(30);
        check("no_leftover_byte", tx_cnt, c0);
        do_frame(8'h02, 8'h03, 8'h04, 0, 0, 1'b0); wait_done();

        // Randomised frames
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            if (k < 4) op = 8'h01;
            else if (k < 8) op = 8'h02;
            else begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'h01 || op == 8'h02) op = 8'($urandom_range(0, 255));
            end
            ga = $urandom_range(0, 4);
            gb = $urandom_range(0, 4);
            k = $urandom_range(0, 19);
            if (k == 0) ga = int'(T) - 1;
            else if (k == 1) gb = int'(T) - 1;
            else if (k == 2) gb = int'(T);
            do_frame(op, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                     ga, gb, ($urandom_range(0, 6) == 0));
            wait_done();
        end

        check("queue_empty_end", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
